// File: rtl/debug_tx_serializer_pkg.sv
// Shared debug-path types: serializer state encoding, word width, byte-count helper.
// Pure declarations, no logic; imported by the serializer, its interface and the bench.
package debug_tx_serializer_pkg;

  localparam int DBG_WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_FIN  = 3'd4
  } dbg_state_t;

  // size field encodes byte count minus one
  function automatic logic [2:0] dbg_byte_count(input logic [1:0] size);
    return {1'b0, size} + 3'd1;
  endfunction

endpackage

// File: rtl/debug_tx_serializer_if.sv
// Decoder-side command bus plus UART-side start/done byte handshake of the debug serializer.
// master = decoder/controller/UART environment, slave = serializer.
interface debug_tx_serializer_if;
  import debug_tx_serializer_pkg::*;

  logic                  start;
  logic [DBG_WORD_W-1:0] result;
  logic [1:0]            size;
  logic                  busy;
  logic                  done;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_done;

  modport master (
    output start, result, size, tx_done,
    input  busy, done, tx_data, tx_start
  );

  modport slave (
    input  start, result, size, tx_done,
    output busy, done, tx_data, tx_start
  );

endinterface

// File: rtl/debug_tx_serializer_gap.sv
// 8-bit down-counter with load and zero flag; paces idle cycles between serialized bytes.
// Load wins over count; counting stops at zero, so no wrap and no backpressure.
module debug_gap_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/debug_tx_serializer.sv
// Serializes a captured 1..4 byte debug word onto a start/done UART handshake.
// First tx_start one cycle after start; next byte 1+GAP_CYCLES after tx_done; waits on tx_done forever.
module debug_tx_serializer
  import debug_tx_serializer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input logic             clk,
  input logic             reset,
  debug_tx_serializer_if.slave bus
);

  dbg_state_t            state;
  logic [DBG_WORD_W-1:0] shreg;
  logic [1:0]            remaining;
  logic                  tx_start_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  gap_zero;

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
      logic gap_load;
      assign gap_load = (state == ST_WAIT) && bus.tx_done && (remaining != 2'd0);
      debug_gap_timer u_gap (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .zero     (gap_zero)
      );
    end else begin : g_nogap
      assign gap_zero = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      remaining  <= 2'd0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            // MSB-first pre-aligns the top selected byte into [31:24]
            if (LSB_FIRST) shreg <= bus.result;
            else           shreg <= bus.result << {2'd3 - bus.size, 3'b000};
            remaining  <= bus.size;
            state      <= ST_SEND;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_SEND: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.tx_done) begin
            if (remaining == 2'd0) begin
              state  <= ST_FIN;
              done_q <= 1'b1;
            end else begin
              remaining <= remaining - 2'd1;
              if (LSB_FIRST) shreg <= shreg >> 8;
              else           shreg <= shreg << 8;
              if (GAP_CYCLES == 0) begin
                state      <= ST_SEND;
                tx_start_q <= 1'b1;
              end else begin
                state <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_zero) begin
            state      <= ST_SEND;
            tx_start_q <= 1'b1;
          end
        end
        ST_FIN: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_data  = LSB_FIRST ? shreg[7:0] : shreg[31:24];
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_debug_tx_serializer.sv
// Directed bench: three serializer variants (LSB/no gap, MSB/no gap, MSB/gap 4) driven from one thread.
module tb_debug_tx_serializer;
  import debug_tx_serializer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  debug_tx_serializer_if bus0();
  debug_tx_serializer_if bus1();
  debug_tx_serializer_if bus2();

  debug_tx_serializer #(.GAP_CYCLES(0), .LSB_FIRST(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  debug_tx_serializer #(.GAP_CYCLES(0), .LSB_FIRST(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  debug_tx_serializer #(.GAP_CYCLES(4), .LSB_FIRST(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic        start_s   [3];
  logic [31:0] result_s  [3];
  logic [1:0]  size_s    [3];
  logic        tx_done_s [3];
  logic        tx_start_o[3];
  logic        busy_o    [3];
  logic        done_o    [3];
  logic [7:0]  tx_data_o [3];

  assign bus0.start = start_s[0];  assign bus0.result = result_s[0];
  assign bus0.size  = size_s[0];   assign bus0.tx_done = tx_done_s[0];
  assign bus1.start = start_s[1];  assign bus1.result = result_s[1];
  assign bus1.size  = size_s[1];   assign bus1.tx_done = tx_done_s[1];
  assign bus2.start = start_s[2];  assign bus2.result = result_s[2];
  assign bus2.size  = size_s[2];   assign bus2.tx_done = tx_done_s[2];

  assign tx_start_o[0] = bus0.tx_start; assign busy_o[0] = bus0.busy;
  assign done_o[0] = bus0.done;         assign tx_data_o[0] = bus0.tx_data;
  assign tx_start_o[1] = bus1.tx_start; assign busy_o[1] = bus1.busy;
  assign done_o[1] = bus1.done;         assign tx_data_o[1] = bus1.tx_data;
  assign tx_start_o[2] = bus2.tx_start; assign busy_o[2] = bus2.busy;
  assign done_o[2] = bus2.done;         assign tx_data_o[2] = bus2.tx_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mon = 0;
  int ack_cnt = 0;
  int ack_delay = 1;
  bit auto_ack = 1'b1;
  int bytes_q[$];
  int start_q[$];
  int txdone_q[$];
  int done_q[$];

  typedef struct {
    int          dut;
    logic [31:0] res;
    logic [1:0]  sz;
    int          dly;
    int          inj;   // loop step at which a stray start is pulsed (0 = none)
    bit          sfin;  // pulse start during the FIN cycle
    int          spur;  // loop step at which a stray tx_done is driven (0 = none)
    logic [31:0] exp;   // expected byte k in exp[8k+:8]
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 2) ? 4 : 0;
  endfunction

  // One negedge: UART model and monitor for the DUT selected by mon.
  task automatic tick();
    @(negedge clk);
    cyc++;
    tx_done_s[mon] = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        tx_done_s[mon] = 1'b1;
        txdone_q.push_back(cyc);
      end
    end
    if (tx_start_o[mon]) begin
      bytes_q.push_back(int'(tx_data_o[mon]));
      start_q.push_back(cyc);
      if (auto_ack) ack_cnt = ack_delay;
    end
    if (done_o[mon]) done_q.push_back(cyc);
  endtask

  task automatic run_xfer(input int idx, input vec_t v);
    int s, n, nb;
    bit finished;
    string p;
    p = $sformatf("v%0d_", idx);
    mon = v.dut;
    ack_delay = v.dly;
    auto_ack = 1'b1;
    ack_cnt = 0;
    bytes_q.delete(); start_q.delete(); txdone_q.delete(); done_q.delete();
    result_s[mon] = v.res;
    size_s[mon] = v.sz;
    start_s[mon] = 1'b1;
    s = cyc;
    n = 0;
    finished = 1'b0;
    while (!finished && n < 300) begin
      tick();
      n++;
      start_s[mon] = 1'b0;
      if (n == 1) begin
        chk({p, "busy_on"}, int'(busy_o[mon]), 1);
        result_s[mon] = ~v.res;
        size_s[mon] = ~v.sz;
      end
      if (n == v.inj) begin
        start_s[mon] = 1'b1;
        result_s[mon] = 32'h1111_1111;
        size_s[mon] = 2'd0;
      end
      if (n == v.spur) tx_done_s[mon] = 1'b1;
      if (done_o[mon]) begin
        finished = 1'b1;
        if (v.sfin) start_s[mon] = 1'b1;
      end
    end
    if (!finished) chk({p, "timeout"}, 0, 1);
    tick();
    start_s[mon] = 1'b0;
    chk({p, "busy_off"}, int'(busy_o[mon]), 0);
    tick();
    chk({p, "idle_busy"}, int'(busy_o[mon]), 0);
    chk({p, "idle_txs"}, int'(tx_start_o[mon]), 0);

    nb = int'(dbg_byte_count(v.sz));
    chk({p, "nstart"}, start_q.size(), nb);
    for (int k = 0; k < nb && k < bytes_q.size(); k++)
      chk($sformatf("%sbyte%0d", p, k), bytes_q[k], int'(v.exp[8*k +: 8]));
    chk({p, "ndone"}, done_q.size(), 1);
    if (start_q.size() > 0) chk({p, "first_lat"}, start_q[0] - s, 1);
    for (int k = 1; k < start_q.size() && k - 1 < txdone_q.size(); k++)
      chk($sformatf("%sgap%0d", p, k), start_q[k] - txdone_q[k-1], 1 + gap_of(v.dut));
    if (done_q.size() > 0 && txdone_q.size() > 0)
      chk({p, "done_lat"}, done_q[0] - txdone_q[txdone_q.size()-1], 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; result_s[i] = '0; size_s[i] = 2'd0; tx_done_s[i] = 1'b0;
    end
    //         dut  result        sz  dly inj sfin spur expected bytes (byte0 in [7:0])
    vecs[0] = '{0, 32'hDEADBEEF, 2'd3, 5, 0, 1'b0, 0, 32'hDEADBEEF};  // EF BE AD DE
    vecs[1] = '{0, 32'h00000055, 2'd0, 1, 0, 1'b0, 0, 32'h00000055};
    vecs[2] = '{1, 32'h00123456, 2'd2, 1, 0, 1'b0, 0, 32'h00563412};  // 12 34 56
    vecs[3] = '{2, 32'h00123456, 2'd2, 3, 0, 1'b0, 0, 32'h00563412};
    vecs[4] = '{0, 32'hA1B2C3D4, 2'd1, 2, 0, 1'b0, 0, 32'h0000C3D4};  // D4 C3
    vecs[5] = '{1, 32'hA1B2C3D4, 2'd3, 2, 0, 1'b0, 0, 32'hD4C3B2A1};  // A1 B2 C3 D4
    vecs[6] = '{1, 32'hA1B2C3D4, 2'd0, 1, 0, 1'b0, 0, 32'h000000D4};
    vecs[7] = '{2, 32'h0000BEEF, 2'd1, 1, 0, 1'b0, 0, 32'h0000EFBE};  // BE EF
    vecs[8] = '{0, 32'hDEADBEEF, 2'd3, 5, 3, 1'b1, 1, 32'hDEADBEEF};
    vecs[9] = '{2, 32'hCAFEF00D, 2'd3, 2, 4, 1'b1, 1, 32'h0DF0FECA};  // CA FE F0 0D

    // reset values while reset is held
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_busy", i), int'(busy_o[i]), 0);
      chk($sformatf("rst%0d_txs", i), int'(tx_start_o[i]), 0);
      chk($sformatf("rst%0d_done", i), int'(done_o[i]), 0);
      chk($sformatf("rst%0d_txd", i), int'(tx_data_o[i]), 0);
    end
    reset = 1'b0;

    // stray tx_done while idle
    mon = 0;
    tick();
    tx_done_s[0] = 1'b1;
    tick();
    chk("idle_spur_busy", int'(busy_o[0]), 0);
    chk("idle_spur_txs", int'(tx_start_o[0]), 0);
    tick();
    chk("idle_spur_txs2", int'(tx_start_o[0]), 0);

    // reset asserted mid-WAIT abandons the transfer without done
    auto_ack = 1'b0;
    ack_cnt = 0;
    done_q.delete();
    result_s[0] = 32'hDEADBEEF;
    size_s[0] = 2'd3;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    tick();
    chk("midwait_busy", int'(busy_o[0]), 1);
    chk("midwait_txd", int'(tx_data_o[0]), 8'hEF);
    reset = 1'b1;
    #1;
    chk("midrst_busy", int'(busy_o[0]), 0);
    chk("midrst_txd", int'(tx_data_o[0]), 0);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("midrst_nodone", done_q.size(), 0);
    chk("midrst_idle", int'(busy_o[0]), 0);

    for (int i = 0; i < 10; i++) run_xfer(i, vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
